gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
Sequencer for a small 2-input combinational gate under test: it drives every (a,b) input combination and waits a programmable settle interval for each one. It then samples the gate output y and records the 4-entry truth table. It compares the table against an expected pattern and reports pass or fail. It sits between a start request (bench or top-level switch) and the gate instance, replacing hand-written stimulus delays with clocked sequencing.

Parameters:
SETTLE_CYCLES, 4, clock cycles each combination is held before y is sampled; legal range 1..255.
EXPECTED, 4'b0110, expected truth table; bit index = {a,b}, so bit0 is a=0,b=0 and bit3 is a=1,b=1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request a sweep; sampled only in IDLE
y  input  1  output of the gate under test
a  output  1  gate input a (registered)
b  output  1  gate input b (registered)
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
truth  output  4  captured truth table, same indexing as EXPECTED
pass  output  1  truth == EXPECTED; valid from done onward

Behaviour:
- Single clock. Reset is asynchronous and active-high.
- Reset values: a=0, b=0, busy=0, done=0, truth=4'b0000, pass=0, state=IDLE, index=0, counter=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - On an edge with start=1: a,b <= combination 0, counter <= SETTLE_CYCLES-1, index <= 0, truth <= 0, pass <= 0, busy <= 1, go to SETTLE.
  - With start=0: outputs hold.
- SETTLE:
  - While counter != 0: counter decrements.
  - When counter == 0: truth[{a,b}] <= y (registered sample).
  - If index < 3: index++, a,b <= next combination, counter reloads SETTLE_CYCLES-1, stay in SETTLE.
  - If index == 3: go to DONE, busy <= 0, done <= 1, pass <= (truth with the new bit merged) == EXPECTED.
- DONE: lasts exactly one cycle. Next edge: done <= 0, a,b <= 0, go to IDLE.
- truth and pass hold until the next accepted start.
- Timing: start sampled at edge E0. Samples occur at E0+S, E0+2S, E0+3S, E0+4S, where S = SETTLE_CYCLES. done is high during the cycle after E0+4S. Total latency from start to done is 4S edges.
- Each combination is driven for exactly S cycles. The gate's propagation delay must be less than S clock periods minus setup time.
- Default sweep order is binary: {a,b} = 00, 01, 10, 11.
- start while busy or in DONE: ignored; no queuing.
- start held high continuously: a new sweep begins on the edge after the return to IDLE. Sweeps are back-to-back with one IDLE cycle between them.
- Reset mid-sweep: immediate return to reset values. Partial truth is discarded.
- SETTLE_CYCLES=1: counter is always 0, so one sample per cycle.

Optional Feature:
Macro GATE_SWEEP_GRAY_EN.
- Defined: sweep order is Gray, {a,b} = 00, 01, 11, 10. Only one input changes per step, which isolates single-input transition delays. truth indexing stays {a,b}, so EXPECTED and pass semantics are unchanged.
- Undefined: binary order 00, 01, 10, 11.
- Timing and latency are identical in both builds.

Decomposition:
- Package gate_sweep_pkg holds:
  - state enum {IDLE, SETTLE, DONE};
  - localparam NUM_COMBOS=4;
  - a function mapping index to {a,b} (binary or Gray, selected by the macro).
- One sub-module, settle_timer: a loadable down-counter with an 8-bit count. Inputs load and load_val; output zero. It is instantiated once in gate_sweep_ctrl.

Test Plan:
- XOR gate model (y = a^b, 2 ns delay), S=4, clk 10 ns, start pulse at 20 ns -> a,b step 00,01,10,11 every 40 ns; done pulses once, 160 ns after the start edge; truth=4'b0110, pass=1, busy low with done.
- AND gate model, EXPECTED=4'b0110 -> truth=4'b1000, pass=0, done still pulses once.
- Assert reset at the third combination sample window -> a=b=0, busy=0, truth=0 asynchronously before the next edge; a new start produces a full correct sweep.
- start pulsed mid-sweep, and start held high -> mid-sweep pulse ignored (exactly one done per sweep); held start gives back-to-back sweeps with one IDLE cycle between done and the next busy.
- S=1 with XOR -> combinations change every cycle; done 4 edges after start; truth=4'b0110.
- Build with GATE_SWEEP_GRAY_EN, XOR model -> drive order 00,01,11,10; truth=4'b0110; pass=1; same latency as the binary build.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and helpers for the gate sweep sequencer.
//   state_t     - sequencer states
//   NUM_COMBOS  - number of (a,b) input combinations swept
//   combo_of()  - maps sweep index to the {a,b} drive value
// Build option: GATE_SWEEP_GRAY_EN selects Gray sweep order (00,01,11,10)
// instead of binary order (00,01,10,11).
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam int unsigned NUM_COMBOS = 4;

  // Returns {a,b} for the given sweep step.
  function automatic logic [1:0] combo_of(input logic [1:0] idx);
`ifdef GATE_SWEEP_GRAY_EN
    return idx ^ {1'b0, idx[1]};
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable 8-bit down-counter that stops at zero.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset, clears count to 0
//   load     - load load_val into the count (has priority over decrement)
//   load_val - value loaded on load
//   zero     - high while the count is zero
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives every (a,b) combination into a 2-input gate, holds
// each for SETTLE_CYCLES clocks, samples y into a 4-entry truth table and
// compares it with EXPECTED.
// Parameters:
//   SETTLE_CYCLES - cycles each combination is held before sampling (1..255)
//   EXPECTED      - expected truth table, bit index {a,b}
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   start - sweep request, honoured only in IDLE
//   y     - gate under test output
//   a, b  - registered gate inputs
//   busy  - high while a sweep is in progress
//   done  - one-cycle pulse at sweep completion
//   truth - captured truth table, bit index {a,b}
//   pass  - truth == EXPECTED, valid from done onward
// Build option: GATE_SWEEP_GRAY_EN selects Gray sweep order (see package).
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECTED      = 4'b0110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic       pass
);

  localparam logic [7:0] RELOAD   = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_COMBOS - 1);

  state_t     r_state;
  logic [1:0] r_index;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_truth;
  logic       r_pass;

  logic       w_zero;
  logic       w_load;
  logic       w_last;
  logic [1:0] w_next_ab;
  logic [3:0] w_truth_merged;

  always_comb begin
    w_last         = (r_index == LAST_IDX);
    w_load         = ((r_state == IDLE) && start) ||
                     ((r_state == SETTLE) && w_zero && !w_last);
    w_next_ab      = combo_of(r_index + 2'd1);
    // Table with the current sample folded in, so pass can be computed on
    // the same edge that captures the final bit.
    w_truth_merged = r_truth;
    w_truth_merged[{r_a, r_b}] = y;
  end

  settle_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (RELOAD),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_truth <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            {r_a, r_b} <= combo_of(2'd0);
            r_index    <= '0;
            r_truth    <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_zero) begin
            r_truth <= w_truth_merged;
            if (!w_last) begin
              r_index    <= r_index + 2'd1;
              {r_a, r_b} <= w_next_ab;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_truth_merged == EXPECTED);
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done     <= 1'b0;
          {r_a, r_b} <= 2'b00;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign busy  = r_busy;
  assign done  = r_done;
  assign truth = r_truth;
  assign pass  = r_pass;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed bench for gate_sweep_ctrl.
// One instance with S=4 drives a selectable XOR/AND gate model, a second
// instance with S=1 drives an XOR model. Honours GATE_SWEEP_GRAY_EN for the
// expected drive order.
module tb_gate_sweep_ctrl;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start1;
  logic       sel_and;
  logic       y;
  logic       y1;
  logic       a, b, busy, done, pass;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] truth, truth1;
  logic [1:0] order [4];

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Gate models with 2 ns propagation delay.
  assign #2 y  = sel_and ? (a & b) : (a ^ b);
  assign #2 y1 = a1 ^ b1;

  gate_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED(4'b0110)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .y     (y),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .truth (truth),
    .pass  (pass)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .y     (y1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .truth (truth1),
    .pass  (pass1)
  );

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full sweep on the S=4 instance starting from IDLE at a negedge.
  // poke=1 pulses start for one cycle in the middle of the sweep.
  task automatic run_sweep(input string tag, input logic [3:0] exp_truth,
                           input logic exp_pass, input bit poke);
    int d0;
    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_clr"}, truth, 4'b0000);
    for (int c = 0; c < int'(4 * S); c++) begin
      start = poke && (c == int'(S) + 1);
      if (c % int'(S) == 0) begin
        check({tag, "_ab"}, {a, b}, order[c / int'(S)]);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (c == int'(4 * S) - 1) check({tag, "_early"}, done, 1'b0);
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy0"}, busy, 1'b0);
    check({tag, "_truth"}, truth, exp_truth);
    check({tag, "_pass"}, pass, exp_pass);
    @(negedge clk);
    check({tag, "_done0"}, done, 1'b0);
    check({tag, "_ab0"}, {a, b}, 2'b00);
    repeat (2 * S) @(negedge clk);
    check({tag, "_hold"}, truth, exp_truth);
    check({tag, "_holdp"}, pass, exp_pass);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
`ifdef GATE_SWEEP_GRAY_EN
    order = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
    order = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif
    reset   = 1'b1;
    start   = 1'b0;
    start1  = 1'b0;
    sel_and = 1'b0;
    #23;
    check("rst_ab", {a, b}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_truth", truth, 4'b0000);
    check("rst_pass", pass, 1'b0);
    check("rst_truth1", truth1, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // XOR gate: matches EXPECTED.
    run_sweep("xor", 4'b0110, 1'b1, 1'b0);

    // AND gate: mismatches EXPECTED.
    sel_and = 1'b1;
    run_sweep("and", 4'b1000, 1'b0, 1'b0);
    sel_and = 1'b0;

    // Reset asserted during the third combination window.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * S + 1) @(negedge clk);
    check("mid_ab", {a, b}, order[2]);
    check("mid_truth", truth, 4'b0010);
    #2 reset = 1'b1;
    #1;
    check("arst_ab", {a, b}, 2'b00);
    check("arst_busy", busy, 1'b0);
    check("arst_truth", truth, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_sweep("post_rst", 4'b0110, 1'b1, 1'b0);

    // start pulsed mid-sweep is ignored.
    run_sweep("poke", 4'b0110, 1'b1, 1'b1);

    // start held high: back-to-back sweeps with one IDLE cycle between.
    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (4 * S) @(negedge clk);
    check("held_done1", done, 1'b1);
    check("held_truth1", truth, 4'b0110);
    @(negedge clk);
    check("held_gap_busy", busy, 1'b0);
    check("held_gap_done", done, 1'b0);
    @(negedge clk);
    check("held_rebusy", busy, 1'b1);
    check("held_clr", truth, 4'b0000);
    check("held_clrp", pass, 1'b0);
    check("held_ab", {a, b}, order[0]);
    start = 1'b0;
    repeat (4 * S) @(negedge clk);
    check("held_done2", done, 1'b1);
    check("held_truth2", truth, 4'b0110);
    check("held_pass2", pass, 1'b1);
    repeat (3) @(negedge clk);
    check("held_end", busy, 1'b0);
    check("held_ndone", done_cnt - d0, 2);

    // S=1 instance: one combination per cycle, done 4 edges after start.
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check("s1_ab0", {a1, b1}, order[0]);
    check("s1_busy", busy1, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("s1_ab", {a1, b1}, order[k]);
    end
    check("s1_early", done1, 1'b0);
    @(negedge clk);
    check("s1_done", done1, 1'b1);
    check("s1_busy0", busy1, 1'b0);
    check("s1_truth", truth1, 4'b0110);
    check("s1_pass", pass1, 1'b1);
    @(negedge clk);
    check("s1_done0", done1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
